// File: rtl/dca_arbiter.sv
// dca_arbiter
//   Multiplexes NumInp DCA requesters onto one shared DCA datapath.
//   Requests are arbitrated round-robin and forwarded with zero latency.
//   The granted requester ID is pushed into an in-order ID FIFO on every
//   master q handshake. Responses from the datapath are routed back to the
//   requester at the FIFO head, which is popped on every master p handshake.
//
//   Optional feature (macro DCA_ARBITER_LOCK_EN):
//     defined   -> a pending, unaccepted grant is locked so that mst_req_o.q
//                  stays stable until the datapath accepts it.
//     undefined -> the grant is recomputed every cycle (default build).
//
// Ports
//   clk_i      in   single clock, all state on the rising edge
//   rst_ni     in   asynchronous active-low reset
//   slv_req_i  in   per-requester request  (q, q_valid, p_ready)
//   slv_rsp_o  out  per-requester response (q_ready, p, p_valid)
//   mst_req_o  out  shared request towards the DCA datapath
//   mst_rsp_i  in   response from the DCA datapath
module dca_arbiter #(
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned NumInp         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type dca_req_t = struct packed {
    logic [DataWidth-1:0] q;
    logic                 q_valid;
    logic                 p_ready;
  },
  parameter type dca_rsp_t = struct packed {
    logic                 q_ready;
    logic [DataWidth-1:0] p;
    logic                 p_valid;
  }
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  dca_req_t slv_req_i [NumInp],
  output dca_rsp_t slv_rsp_o [NumInp],
  output dca_req_t mst_req_o,
  input  dca_rsp_t mst_rsp_i
);

  localparam int unsigned IdW  = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdW-1:0]  id_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  // Round-robin pointer and ID FIFO state
  id_t  rr_q;
  id_t  rr_next;
  ptr_t head_reg;
  ptr_t tail_reg;
  cnt_t count_reg;
  id_t  id_mem [MaxOutstanding];

  // Arbitration and handshake signals
  logic arb_found;
  id_t  arb_id;
  id_t  grant_id;
  id_t  head_id;
  logic fifo_full;
  logic fifo_empty;
  logic mst_q_valid;
  logic mst_p_ready;
  logic q_hs;
  logic p_hs;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Round-robin search starting at rr_q; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NumInp) idx = idx - NumInp;
      if (!arb_found && slv_req_i[idx].q_valid) begin
        arb_found = 1'b1;
        arb_id    = id_t'(idx);
      end
    end
  end

`ifdef DCA_ARBITER_LOCK_EN
  logic lock_reg;
  id_t  lock_id_reg;

  // The lock only applies while the locked requester keeps its request up;
  // if it withdraws, arbitration falls back to the round-robin result.
  assign grant_id = (lock_reg && slv_req_i[lock_id_reg].q_valid) ? lock_id_reg : arb_id;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
    end else begin
      lock_reg    <= mst_q_valid && !mst_rsp_i.q_ready;
      lock_id_reg <= grant_id;
    end
  end
`else
  assign grant_id = arb_id;
`endif

  assign fifo_full  = (count_reg == cnt_t'(MaxOutstanding));
  assign fifo_empty = (count_reg == '0);
  assign head_id    = id_mem[head_reg];

  // Fullness comes straight from the registered count, so a pop in the
  // same cycle never opens the q-side: no p-side to q-side combinational path.
  assign mst_q_valid = rst_ni && arb_found && !fifo_full;
  assign mst_p_ready = rst_ni && !fifo_empty && slv_req_i[head_id].p_ready;
  assign q_hs        = mst_q_valid && mst_rsp_i.q_ready;
  assign p_hs        = mst_p_ready && mst_rsp_i.p_valid;

  assign rr_next = (grant_id == id_t'(NumInp - 1)) ? '0 : grant_id + id_t'(1);

  always_comb begin
    mst_req_o         = '0;
    mst_req_o.q       = slv_req_i[grant_id].q;
    mst_req_o.q_valid = mst_q_valid;
    mst_req_o.p_ready = mst_p_ready;
  end

  for (genvar gi = 0; gi < NumInp; gi++) begin : g_slv_rsp
    always_comb begin
      slv_rsp_o[gi]         = '0;
      slv_rsp_o[gi].q_ready = rst_ni && arb_found && !fifo_full &&
                              mst_rsp_i.q_ready && (grant_id == id_t'(gi));
      if (rst_ni && !fifo_empty && (head_id == id_t'(gi))) begin
        slv_rsp_o[gi].p       = mst_rsp_i.p;
        slv_rsp_o[gi].p_valid = mst_rsp_i.p_valid;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (q_hs) begin
        rr_q     <= rr_next;
        tail_reg <= ptr_inc(tail_reg);
      end
      if (p_hs) begin
        head_reg <= ptr_inc(head_reg);
      end
      case ({q_hs, p_hs})
        2'b10:   count_reg <= count_reg + cnt_t'(1);
        2'b01:   count_reg <= count_reg - cnt_t'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (q_hs) begin
      id_mem[tail_reg] <= grant_id;
    end
  end

endmodule

// File: tb/tb_dca_arbiter.sv
`timescale 1ns/1ps
module tb_dca_arbiter;

  localparam int DW = 16;
  localparam int NI = 4;
  localparam int MO = 2;

  typedef struct packed {
    logic [DW-1:0] q;
    logic          q_valid;
    logic          p_ready;
  } req_t;

  typedef struct packed {
    logic          q_ready;
    logic [DW-1:0] p;
    logic          p_valid;
  } rsp_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;

  req_t slv_req [NI];
  rsp_t slv_rsp [NI];
  req_t mst_req;
  rsp_t mst_rsp;

  // Requester side: per-port queues of pending request data
  logic [DW-1:0] port_q [NI][$];
  logic          drv_valid [NI];
  logic [DW-1:0] drv_data [NI];
  logic          p_rdy [NI];

  // Datapath model: answers each accepted q with q+1, in order
  logic          dp_q_ready;
  logic          dp_p_en;
  logic          dp_stray;
  logic          dp_p_valid;
  logic [DW-1:0] dp_p;
  logic [DW-1:0] pend [$];

  txn_t exp_grant [$];
  txn_t exp_rsp [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_req
    assign slv_req[gi] = {drv_data[gi], drv_valid[gi], p_rdy[gi]};
  end
  assign mst_rsp = {dp_q_ready, dp_p, dp_p_valid | dp_stray};

  dca_arbiter #(
    .DataWidth(DW),
    .NumInp(NI),
    .MaxOutstanding(MO),
    .dca_req_t(req_t),
    .dca_rsp_t(rsp_t)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .slv_req_i(slv_req),
    .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req),
    .mst_rsp_i(mst_rsp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_p_valid();
    logic r = 1'b0;
    for (int i = 0; i < NI; i++) r = r | slv_rsp[i].p_valid;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int p, input logic [DW-1:0] d);
    port_q[p].push_back(d);
  endtask

  task automatic exp_txn(input int p, input logic [DW-1:0] d, input bit has_rsp);
    txn_t t;
    t.port = p;
    t.data = d;
    exp_grant.push_back(t);
    if (has_rsp) begin
      t.data = d + 16'h1;
      exp_rsp.push_back(t);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int k = 0;
    while ((exp_grant.size() + exp_rsp.size()) != 0 && k < max_cycles) begin
      step(1);
      k++;
    end
    check(name, exp_grant.size() + exp_rsp.size(), 0);
  endtask

  // Driver: requesters and datapath model react to handshakes sampled mid-cycle
  initial begin : driver
    logic          acc [NI];
    logic          qhs;
    logic          phs;
    logic [DW-1:0] qd;
    for (int i = 0; i < NI; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = '0;
    end
    dp_p_valid = 1'b0;
    dp_p       = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) acc[i] = slv_req[i].q_valid && slv_rsp[i].q_ready;
      qhs = mst_req.q_valid && mst_rsp.q_ready;
      phs = mst_rsp.p_valid && mst_req.p_ready;
      qd  = mst_req.q;
      @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++)
        if (acc[i] && port_q[i].size() > 0) void'(port_q[i].pop_front());
      if (!rst_n) begin
        pend.delete();
      end else begin
        if (phs && pend.size() > 0) void'(pend.pop_front());
        if (qhs) pend.push_back(qd + 16'h1);
      end
      for (int i = 0; i < NI; i++) begin
        drv_valid[i] = (port_q[i].size() > 0);
        drv_data[i]  = (port_q[i].size() > 0) ? port_q[i][0] : '0;
      end
      dp_p_valid = dp_p_en && (pend.size() > 0);
      dp_p       = (pend.size() > 0) ? pend[0] : '0;
    end
  end

  // Monitor: pops the scoreboard whenever a handshake is presented
  always @(negedge clk) begin : monitor
    int   gp;
    int   n;
    txn_t t;
    if (rst_n) begin
      if (mst_req.q_valid && mst_rsp.q_ready) begin
        gp = -1;
        n  = 0;
        for (int i = 0; i < NI; i++)
          if (slv_rsp[i].q_ready) begin
            gp = i;
            n++;
          end
        if (exp_grant.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: port %0d q 0x%0h, nothing expected", gp, mst_req.q);
        end else begin
          t = exp_grant.pop_front();
          $display("grant    port %0d q 0x%0h (expected port %0d q 0x%0h)", gp, mst_req.q, t.port, t.data);
          check("grant_port", gp, t.port);
          check("grant_q", mst_req.q, t.data);
          check("q_ready_onehot", n, 1);
        end
      end
      for (int i = 0; i < NI; i++) begin
        if (slv_rsp[i].p_valid && slv_req[i].p_ready) begin
          if (exp_rsp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: port %0d p 0x%0h, nothing expected", i, slv_rsp[i].p);
          end else begin
            t = exp_rsp.pop_front();
            $display("response port %0d p 0x%0h (expected port %0d p 0x%0h)", i, slv_rsp[i].p, t.port, t.data);
            check("rsp_port", i, t.port);
            check("rsp_p", slv_rsp[i].p, t.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int i = 0; i < NI; i++) p_rdy[i] = 1'b1;
    rst_n      = 1'b0;
    dp_q_ready = 1'b1;
    dp_p_en    = 1'b1;
    dp_stray   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mst_q_valid", mst_req.q_valid, 0);
    check("reset_mst_p_ready", mst_req.p_ready, 0);
    check("reset_any_p_valid", any_p_valid(), 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Back-to-back round robin: grants 0,1,2,3,0 on consecutive cycles
    issue(0, 16'h10); issue(1, 16'h11); issue(2, 16'h12); issue(3, 16'h13); issue(0, 16'h20);
    exp_txn(0, 16'h10, 1); exp_txn(1, 16'h11, 1); exp_txn(2, 16'h12, 1);
    exp_txn(3, 16'h13, 1); exp_txn(0, 16'h20, 1);
    step(5);
    check("rr_back_to_back_done", exp_grant.size(), 0);
    wait_drain("rr_drain", 20);

    // Out-of-order arrival: port 2 then port 0, results routed by issue order
    dp_p_en = 1'b0;
    issue(2, 16'h9);
    exp_txn(2, 16'h9, 1);
    step(1);
    issue(0, 16'hA);
    exp_txn(0, 16'hA, 1);
    step(3);
    dp_p_en = 1'b1;
    wait_drain("order_drain", 20);

    // Full FIFO blocks the third request, even in the cycle of the first pop
    dp_p_en = 1'b0;
    issue(1, 16'h30); issue(2, 16'h31); issue(3, 16'h32);
    exp_txn(1, 16'h30, 1); exp_txn(2, 16'h31, 1); exp_txn(3, 16'h32, 1);
    step(2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("full_mst_q_valid", mst_req.q_valid, 0);
      check("full_port3_q_ready", slv_rsp[3].q_ready, 0);
      step(1);
    end
    dp_p_en = 1'b1;
    @(negedge clk);
    check("pop_cycle_p_hs", mst_rsp.p_valid && mst_req.p_ready, 1);
    check("pop_cycle_port3_q_ready", slv_rsp[3].q_ready, 0);
    step(1);
    @(negedge clk);
    check("after_pop_port3_q_ready", slv_rsp[3].q_ready, 1);
    wait_drain("full_drain", 20);

    // Head requester not ready: result held, no pop
    p_rdy[0] = 1'b0;
    issue(0, 16'h40);
    exp_txn(0, 16'h40, 1);
    step(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_mst_p_ready", mst_req.p_ready, 0);
      check("hold_p_valid", slv_rsp[0].p_valid, 1);
      check("hold_p", slv_rsp[0].p, 16'h41);
      step(1);
    end
    p_rdy[0] = 1'b1;
    wait_drain("hold_drain", 20);

    // Reset with two outstanding IDs
    dp_p_en = 1'b0;
    issue(1, 16'h50); issue(2, 16'h51);
    exp_txn(1, 16'h50, 0); exp_txn(2, 16'h51, 0);
    step(4);
    check("pre_reset_grants", exp_grant.size(), 0);
    rst_n    = 1'b0;
    dp_stray = 1'b1;
    issue(0, 16'h60); issue(3, 16'h61);
    @(negedge clk);
    check("mid_reset_mst_q_valid", mst_req.q_valid, 0);
    check("mid_reset_mst_p_ready", mst_req.p_ready, 0);
    check("mid_reset_port0_q_ready", slv_rsp[0].q_ready, 0);
    check("mid_reset_any_p_valid", any_p_valid(), 0);
    step(1);
    dp_q_ready = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    check("empty_mst_p_ready", mst_req.p_ready, 0);
    check("empty_p_valid_ignored", any_p_valid(), 0);
    check("post_reset_grant_q", mst_req.q, 16'h60);
    step(1);
    dp_stray   = 1'b0;
    dp_q_ready = 1'b1;
    dp_p_en    = 1'b1;
    exp_txn(0, 16'h60, 1); exp_txn(3, 16'h61, 1);
    wait_drain("reset_drain", 20);

    // Stalled datapath: ports 1 and 3 wait, port 0 joins one cycle later
    dp_q_ready = 1'b0;
    issue(1, 16'h70); issue(3, 16'h71);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_mst_q_valid", mst_req.q_valid, 1);
`ifdef DCA_ARBITER_LOCK_EN
      check("stall_mst_q_locked", mst_req.q, 16'h70);
`else
      check("stall_mst_q", mst_req.q, (k == 0) ? 16'h70 : 16'h72);
`endif
      step(1);
      if (k == 0) issue(0, 16'h72);
    end
    dp_q_ready = 1'b1;
`ifdef DCA_ARBITER_LOCK_EN
    exp_txn(1, 16'h70, 1); exp_txn(3, 16'h71, 1); exp_txn(0, 16'h72, 1);
`else
    exp_txn(0, 16'h72, 1); exp_txn(1, 16'h70, 1); exp_txn(3, 16'h71, 1);
`endif
    wait_drain("stall_drain", 20);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
